antirrebote_pulso: RTL
======================

ANTIRREBOTE_PULSO -- requirements
Module: antirrebote_pulso

Interface
REQ-001 Parameter DEB_TICKS, default 120000: consecutive stable clk cycles required to accept a new button level (10 ms at 12 MHz).
REQ-002 Parameter REP_DELAY, default 6000000: held-press cycles before auto-repeat starts (0.5 s at 12 MHz).
REQ-003 Parameter REP_PERIOD, default 1200000: cycles between auto-repeat pulses (0.1 s at 12 MHz).
REQ-004 Parameter REP_EN, default 1: 1 enables auto-repeat, 0 disables it.
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 btn_up  input  1  raw asynchronous push-button, active-high (pressed = 1).
REQ-008 btn_down  input  1  raw asynchronous push-button, active-high.
REQ-009 up  output  1  one-cycle increment pulse, registered; drives the up/down counter's up input.
REQ-010 down  output  1  one-cycle decrement pulse, registered; drives the counter's down input.
REQ-011 up_held, down_held  output  1 each  debounced button levels, registered.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer before any other logic; raw inputs feed nothing else.
REQ-013 Each channel SHALL run an FSM with states REL (released), PRESS_CHK, HELD, REL_CHK.
REQ-014 REL: sync input 1 -> PRESS_CHK with stability counter cleared; else stay.
REQ-015 PRESS_CHK: input 0 -> REL (bounce rejected, no pulse); input 1 for DEB_TICKS consecutive cycles -> HELD.
REQ-016 HELD: input 0 -> REL_CHK with counter cleared; REL_CHK: input 1 -> HELD (no pulse), input 0 for DEB_TICKS cycles -> REL.
REQ-017 Entering HELD SHALL assert the channel pulse for exactly one cycle, on the cycle after the transition.
REQ-018 Total latency from first stable raw 1 to pulse: 2 (sync) + DEB_TICKS + 1 cycles.
REQ-019 held output SHALL be 1 in HELD and REL_CHK, 0 in REL and PRESS_CHK.
REQ-020 With REP_EN=1, continuous residence in HELD for REP_DELAY cycles SHALL emit a pulse, then one every REP_PERIOD cycles while still in HELD.
REQ-021 Repeat timer SHALL clear on leaving HELD; a bounce into REL_CHK and back to HELD restarts REP_DELAY.
REQ-022 Stability and repeat counters SHALL be sized by ceiling log2 of their max parameter and SHALL saturate, never wrap.
REQ-023 If both channels would pulse in the same cycle, both up and down SHALL stay 0 that cycle (no net-zero count glitch); no pulse is deferred.
REQ-024 up and down SHALL never be 1 simultaneously.
REQ-025 A button held through reset deassertion SHALL produce a pulse only after the full DEB_TICKS debounce from REL.

Reset
REQ-026 reset SHALL force both FSMs to REL, clear synchronizers, stability and repeat counters, at the next clk edge.
REQ-027 During and in the cycle after reset, up, down, up_held, down_held SHALL be 0.
REQ-028 Reset mid-debounce or mid-repeat SHALL abandon the operation without emitting a pulse.

Structure
REQ-029 Shared package antirrebote_pkg SHALL hold FSM state encoding and default timing constants for 12 MHz.
REQ-030 One sub-module antirrebote_canal (synchronizer, FSM, counters, pulse, held) SHALL be instantiated per button; top holds only the REQ-023 arbitration and output registers.

Verification (DEB_TICKS=4, REP_DELAY=20, REP_PERIOD=5)
REQ-031 Reset 3 cycles with btn_up=1 held -> outputs 0 during reset; single up pulse 7 cycles after reset release; up_held=1.
REQ-032 btn_up bounces 1,0,1,0 per cycle, then stable 1 -> no pulse during bounce; exactly one up pulse 7 cycles after last rising edge.
REQ-033 btn_down held 40 cycles -> pulses at press debounce, then 20 and 25 and 30 and 35 cycles later; none after release.
REQ-034 btn_up and btn_down rise same cycle, both stable -> up=down=0 throughout; both held=1.
REQ-035 Release with 2-cycle glitch back to 1 -> no new pulse; held stays 1; repeat timer restarts.
REQ-036 Reset asserted mid-PRESS_CHK -> no pulse; FSM in REL; held=0.

Source files
------------

// File: rtl/antirrebote_pkg.sv
// Shared state encoding and 12 MHz default timing for the button debouncer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package antirrebote_pkg;

  typedef enum logic [1:0] {
    REL       = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } canal_state_t;

  // Default timing for a 12 MHz clk.
  localparam int unsigned CLK_HZ         = 12_000_000;
  localparam int unsigned DEB_TICKS_DEF  = 120_000;    // 10 ms
  localparam int unsigned REP_DELAY_DEF  = 6_000_000;  // 0.5 s
  localparam int unsigned REP_PERIOD_DEF = 1_200_000;  // 0.1 s

  // Counter width: ceiling log2 of the largest value to be counted, at least 1 bit.
  function automatic int cnt_width(input int unsigned max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/antirrebote_canal.sv
// One button channel: 2-flop synchronizer, debounce FSM, auto-repeat timer.
// Latency: pulse strobe (combinational) on the edge that enters HELD, 2 + DEB_TICKS cycles after the raw rise.
// Backpressure: none; free-running, strobes are never held off or deferred.
module antirrebote_canal
  import antirrebote_pkg::*;
#(
  parameter int unsigned DEB_TICKS  = DEB_TICKS_DEF,
  parameter int unsigned REP_DELAY  = REP_DELAY_DEF,
  parameter int unsigned REP_PERIOD = REP_PERIOD_DEF,
  parameter bit          REP_EN     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse,
  output logic held
);

  localparam int          DW       = cnt_width(DEB_TICKS);
  localparam int unsigned REP_MAX  = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int          RW       = cnt_width(REP_MAX);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_TICKS - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REP_PERIOD - 1);

  logic          sync_1, sync_2;
  canal_state_t  state_q, state_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_rpt_q, rep_rpt_d;  // 0: waiting initial delay, 1: periodic phase
  logic [RW-1:0] rep_last;

  // Two-flop synchronizer; the raw button feeds nothing else.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= REL;
      deb_cnt_q <= '0;
      rep_cnt_q <= '0;
      rep_rpt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      rep_rpt_q <= rep_rpt_d;
    end
  end

  assign rep_last = rep_rpt_q ? PER_LAST : DLY_LAST;

  // Next state, saturating counters and pulse strobe; the repeat timer is cleared outside HELD.
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    rep_cnt_d = '0;
    rep_rpt_d = 1'b0;
    pulse     = 1'b0;
    held      = (state_q == HELD) || (state_q == REL_CHK);
    case (state_q)
      REL: begin
        if (sync_2) begin
          state_d   = PRESS_CHK;
          deb_cnt_d = '0;
        end
      end
      PRESS_CHK: begin
        if (!sync_2) begin
          state_d = REL;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d = HELD;
          pulse   = 1'b1;
        end else begin
          deb_cnt_d = (deb_cnt_q == '1) ? deb_cnt_q : deb_cnt_q + DW'(1);
        end
      end
      HELD: begin
        if (!sync_2) begin
          state_d   = REL_CHK;
          deb_cnt_d = '0;
        end else if (REP_EN) begin
          rep_rpt_d = rep_rpt_q;
          if (rep_cnt_q == rep_last) begin
            pulse     = 1'b1;
            rep_cnt_d = '0;
            rep_rpt_d = 1'b1;
          end else begin
            rep_cnt_d = (rep_cnt_q == '1) ? rep_cnt_q : rep_cnt_q + RW'(1);
          end
        end
      end
      REL_CHK: begin
        if (sync_2) begin
          state_d = HELD;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d = REL;
        end else begin
          deb_cnt_d = (deb_cnt_q == '1) ? deb_cnt_q : deb_cnt_q + DW'(1);
        end
      end
      default: state_d = REL;
    endcase
  end

endmodule

// File: rtl/antirrebote_pulso.sv
// Two debounced buttons to registered up/down count pulses with auto-repeat.
// Latency: 2 (sync) + DEB_TICKS + 1 cycles from first stable raw 1 to the up/down pulse.
// Backpressure: none; coincident up and down pulses cancel each other and are dropped, never deferred.
module antirrebote_pulso
  import antirrebote_pkg::*;
#(
  parameter int unsigned DEB_TICKS  = DEB_TICKS_DEF,
  parameter int unsigned REP_DELAY  = REP_DELAY_DEF,
  parameter int unsigned REP_PERIOD = REP_PERIOD_DEF,
  parameter bit          REP_EN     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic up,
  output logic down,
  output logic up_held,
  output logic down_held
);

  logic up_pulse, up_lvl;
  logic dn_pulse, dn_lvl;

  antirrebote_canal #(
    .DEB_TICKS (DEB_TICKS),
    .REP_DELAY (REP_DELAY),
    .REP_PERIOD(REP_PERIOD),
    .REP_EN    (REP_EN)
  ) u_up (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_up),
    .pulse(up_pulse),
    .held (up_lvl)
  );

  antirrebote_canal #(
    .DEB_TICKS (DEB_TICKS),
    .REP_DELAY (REP_DELAY),
    .REP_PERIOD(REP_PERIOD),
    .REP_EN    (REP_EN)
  ) u_down (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_down),
    .pulse(dn_pulse),
    .held (dn_lvl)
  );

  // Output registers; simultaneous pulses are suppressed so the counter never sees up and down together.
  always_ff @(posedge clk) begin
    if (reset) begin
      up        <= 1'b0;
      down      <= 1'b0;
      up_held   <= 1'b0;
      down_held <= 1'b0;
    end else begin
      up        <= up_pulse & ~dn_pulse;
      down      <= dn_pulse & ~up_pulse;
      up_held   <= up_lvl;
      down_held <= dn_lvl;
    end
  end

endmodule
